// File: rtl/mem_pkg.sv
// Shared definitions for the word-wide memory slave and its cache-side peers.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam int unsigned CNT_W                = 4;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned LINE_WORDS_WIDTH_DEF = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port; contents are not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] idx,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
    dout <= mem[idx];
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory slave with programmable wait states and a one-cycle ack.
// Optional MEM_FAST_SEQ_EN shortens in-line sequential accesses to FAST_LATENCY.
module mem_wait_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BITS       = 10,
  parameter int unsigned LATENCY          = 4,
  parameter int unsigned FAST_LATENCY     = 1,
  parameter int unsigned LINE_WORDS_WIDTH = LINE_WORDS_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        proto_err_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end
  if (FAST_LATENCY < 1 || FAST_LATENCY > LATENCY) begin : g_bad_fast_latency
    $error("FAST_LATENCY must be in 1..LATENCY");
  end
  if (LINE_WORDS_WIDTH >= DEPTH_BITS) begin : g_bad_line
    $error("LINE_WORDS_WIDTH must be below DEPTH_BITS");
  end

  localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, lat_cnt;
  logic [31:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           rd_data_q, arr_dout;
  logic                  err_q, err_set;
  logic [DEPTH_BITS-1:0] req_idx, cur_idx, arr_idx;
  logic                  acking, aborting, arr_we;

  assign req_idx  = addr_i[DEPTH_BITS+1:2];
  assign cur_idx  = addr_q[DEPTH_BITS+1:2];
  assign acking   = (state_q == S_ACK);
  assign aborting = (state_q == S_WAIT) && !cs_i;
  assign err_set  = (((state_q == S_WAIT) && cs_i) || acking) &&
                    ((addr_i != addr_q) || (we_i != we_q));

  // In idle the array is pointed at the incoming index so a 1-cycle access has data in S_ACK.
  assign arr_idx = (state_q == S_IDLE) ? req_idx : cur_idx;
  assign arr_we  = acking && we_q && !rst;

`ifdef MEM_FAST_SEQ_EN
  localparam logic [CNT_W-1:0] FAST_CNT = CNT_W'(FAST_LATENCY - 1);

  logic [DEPTH_BITS-1:0] last_idx_q, next_idx;
  logic                  last_vld_q, seq_hit;

  assign next_idx = last_idx_q + 1'b1;
  assign seq_hit  = last_vld_q && (req_idx == next_idx) &&
                    (req_idx[DEPTH_BITS-1:LINE_WORDS_WIDTH] ==
                     last_idx_q[DEPTH_BITS-1:LINE_WORDS_WIDTH]);
  assign lat_cnt  = seq_hit ? FAST_CNT : SLOW_CNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q <= '0;
      last_vld_q <= 1'b0;
    end else if (acking) begin
      last_idx_q <= cur_idx;
      last_vld_q <= 1'b1;
    end else if (aborting) begin
      last_vld_q <= 1'b0;
    end
  end
`else
  assign lat_cnt = SLOW_CNT;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (cs_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          cnt_d   = lat_cnt;
          state_d = (lat_cnt == '0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (aborting) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          // Last wait cycle: counter reaches zero as the FSM enters S_ACK.
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      if (acking && !we_q) begin
        rd_data_q <= arr_dout;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_array #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .idx (arr_idx),
    .din (data_i),
    .dout(arr_dout)
  );

  assign ack_o       = acking;
  assign data_o      = (acking && !we_q) ? arr_dout : rd_data_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Scoreboard bench for mem_wait_ctrl: directed scenarios plus randomized traffic vs a word model.
module tb_mem_wait_ctrl;

  localparam int LAT  = 4;
  localparam int FLAT = 1;
  localparam int DB   = 10;
  localparam int LWW  = 2;
`ifdef MEM_FAST_SEQ_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        perr;

  mem_wait_ctrl #(
    .DEPTH_BITS      (DB),
    .LATENCY         (LAT),
    .FAST_LATENCY    (FLAT),
    .LINE_WORDS_WIDTH(LWW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (cs),
    .we_i       (we),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (rdata),
    .ack_o      (ack),
    .proto_err_o(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ack_cyc;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[int];
  int          last_idx = 0;
  bit          last_vld = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          hold_chk = 1'b0;
  logic [31:0] hold_val = '0;
  logic        prev_ack = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  // Latency rule: fast only for the next word of the same line after an acked access.
  function automatic int exp_lat(int idx);
    bit seq;
    seq = last_vld && (idx == last_idx + 1) && ((idx >> LWW) == (last_idx >> LWW));
    return (FAST_EN && seq) ? FLAT : LAT;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("data_hold", rdata, hold_val);
        hold_chk = 1'b0;
      end
      if (prev_ack) check("ack_single_cycle", {31'b0, ack}, 32'd0);
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", {31'b0, ack}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          if (e.chk) begin
            check("read_data", rdata, e.data);
            hold_chk = 1'b1;
            hold_val = e.data;
          end
        end
      end
      prev_ack = ack;
    end
  end

  task automatic push_exp(input bit w, input int idx, input int c0, input int lat);
    exp_t e;
    e.ack_cyc = c0 + lat;
    e.chk     = !w && model.exists(idx);
    e.data    = '0;
    if (e.chk) e.data = model[idx];
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int c0, output int lat_meas);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 40);
    if (!ack) begin
      check("ack_timeout", {31'b0, ack}, 32'd1);
      exp_q.delete();
      lat_meas = -1;
    end else begin
      lat_meas = cyc - c0;
    end
  endtask

  // Issue one request (called #1 after a posedge); returns with cs low, #1 after the post-ack edge.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int lat_meas);
    int idx, c0;
    idx = int'(a[DB+1:2]);
    c0  = cyc;
    push_exp(w, idx, c0, exp_lat(idx));
    cs = 1'b1; we = w; addr = a; wdata = d;
    wait_ack(c0, lat_meas);
    if (w) model[idx] = d;
    last_idx = idx;
    last_vld = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lm, c0;
    int lats[5];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_data", rdata, 32'd0);
    check("reset_perr", {31'b0, perr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: write then read back
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, lm);
    check("t1_wr_latency", 32'(lm), 32'(LAT));
    do_req(1'b0, 32'h40, 32'h0, lm);
    check("t1_rd_latency", 32'(lm), 32'(LAT));

    // 2: back-to-back reads
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'h100 + 32'(4 * i), $urandom(), lm);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'h100 + 32'(4 * i), 32'h0, lm);
      if (i == 0) check("t2_first_latency", 32'(lm), 32'(LAT));
    end

    // 3: abort a write in its second wait cycle
    do_req(1'b1, 32'h80, 32'h1111_1111, lm);
    cs = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'h2222_2222;
    @(posedge clk); @(posedge clk); #1;
    cs = 1'b0;
    last_vld = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    do_req(1'b0, 32'h80, 32'h0, lm);
    check("t3_after_abort_latency", 32'(lm), 32'(LAT));

    // 5: sequential reads across a line boundary
    for (int i = 0; i < 5; i++) do_req(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), lm);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 32'h10 + 32'(4 * i), 32'h0, lm);
      lats[i] = lm;
    end
    check("t5_lat0", 32'(lats[0]), 32'(LAT));
    check("t5_lat1", 32'(lats[1]), FAST_EN ? 32'(FLAT) : 32'(LAT));
    check("t5_lat2", 32'(lats[2]), FAST_EN ? 32'(FLAT) : 32'(LAT));
    check("t5_lat3", 32'(lats[3]), FAST_EN ? 32'(FLAT) : 32'(LAT));
    check("t5_lat4", 32'(lats[4]), 32'(LAT));

    // 4: address changes mid-wait; access completes on the latched address
    do_req(1'b1, 32'h20, 32'h2020_2020, lm);
    do_req(1'b1, 32'h24, 32'h2424_2424, lm);
    check("t4_perr_clear", {31'b0, perr}, 32'd0);
    c0 = cyc;
    push_exp(1'b0, 8, c0, exp_lat(8));
    cs = 1'b1; we = 1'b0; addr = 32'h20;
    @(posedge clk); #1;
    addr = 32'h24;
    wait_ack(c0, lm);
    last_idx = 8;
    last_vld = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
    check("t4_perr_set", {31'b0, perr}, 32'd1);
    repeat (4) @(negedge clk);
    check("t4_perr_sticky", {31'b0, perr}, 32'd1);
    @(posedge clk); #1;

    // 6: reset in the middle of a write
    do_req(1'b1, 32'h0C, 32'hC0C0_C0C0, lm);
    cs = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hBAD0_BAD0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cs = 1'b0;
    last_vld = 1'b0;
    @(negedge clk);
    check("t6_ack_after_rst", {31'b0, ack}, 32'd0);
    check("t6_perr_after_rst", {31'b0, perr}, 32'd0);
    check("t6_data_after_rst", rdata, 32'd0);
    @(posedge clk); #1;
    do_req(1'b0, 32'h0C, 32'h0, lm);
    check("t6_idle_latency", 32'(lm), 32'(LAT));

    // Randomized traffic with sequential bias and upper-bit aliasing
    for (int i = 0; i < 80; i++) begin
      int          idx, gap;
      logic [31:0] a;
      bit          w;
      if (last_vld && $urandom_range(1, 0) == 1) idx = (last_idx + 1) % (1 << DB);
      else idx = int'($urandom_range(0, 31));
      a = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0);
      do_req(w, a, $urandom(), lm);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("perr_end", {31'b0, perr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
